// File: rtl/cpu_bus_tracer.sv
// cpu_bus_tracer
// Captures one 6502 external bus cycle per cycle_strobe into a FIFO and
// streams each captured cycle to the LCD controller as a 10-character
// ASCII record: "AAAA DD RS" (address, data, R/W, '*' on opcode fetch).
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   enable                capture enable (draining continues when low)
//   cycle_strobe          one-clk pulse per CPU cycle; addr/data/rw/sync valid
//   addr, data, rw, sync  bus sample
//   init_done             LCD ready; gates the start of each record
//   write_done            LCD finished the current clear or character
//   write_start           pulse: data_out valid, write it
//   data_out              ASCII character
//   clear_all             pulse: clear the LCD before a record
//   overflow              sticky: a sample was dropped
//   drop_count            dropped samples, saturating at 255
//   fifo_level            current FIFO occupancy
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for a queued entry and init_done; pops + clears
// WAIT_CLR | clear_all issued, waiting for write_done
// SEND     | presents char[idx] and pulses write_start
// WAIT_CHR | waiting for write_done of char[idx]
module cpu_bus_tracer #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   cycle_strobe,
    input  logic [15:0]            addr,
    input  logic [7:0]             data,
    input  logic                   rw,
    input  logic                   sync,
    input  logic                   init_done,
    input  logic                   write_done,
    output logic                   write_start,
    output logic [7:0]             data_out,
    output logic                   clear_all,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_CLR, SEND, WAIT_CHR} state_t;

    logic [25:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push_req, push, pop;

    state_t        state, state_next;
    logic [3:0]    idx, idx_next;
    logic [25:0]   record;
    logic [7:0]    char_sel, data_next;
    logic          clear_next, start_next;

    assign full     = (fifo_level == FULL_LVL);
    assign empty    = (fifo_level == '0);
    assign push_req = cycle_strobe && enable;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {addr, data, rw, sync};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (push_req && !push) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            end
        end
    end

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // record = {addr[15:0], data[7:0], rw, sync}
    always_comb begin
        char_sel = 8'h20;
        case (idx)
            4'd0: char_sel = hex_char(record[25:22]);
            4'd1: char_sel = hex_char(record[21:18]);
            4'd2: char_sel = hex_char(record[17:14]);
            4'd3: char_sel = hex_char(record[13:10]);
            4'd5: char_sel = hex_char(record[9:6]);
            4'd6: char_sel = hex_char(record[5:2]);
            4'd8: char_sel = record[1] ? 8'h52 : 8'h57;
            4'd9: char_sel = record[0] ? 8'h2A : 8'h20;
            default: char_sel = 8'h20;
        endcase
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        pop        = 1'b0;
        clear_next = 1'b0;
        start_next = 1'b0;
        data_next  = data_out;
        case (state)
            IDLE: begin
                if (init_done && !empty) begin
                    pop        = 1'b1;
                    clear_next = 1'b1;
                    state_next = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (write_done) begin
                    idx_next   = 4'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                data_next  = char_sel;
                start_next = 1'b1;
                state_next = WAIT_CHR;
            end
            WAIT_CHR: begin
                if (write_done) begin
                    if (idx == 4'd9) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + 4'd1;
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 4'd0;
            record      <= '0;
            clear_all   <= 1'b0;
            write_start <= 1'b0;
            data_out    <= 8'h00;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            clear_all   <= clear_next;
            write_start <= start_next;
            data_out    <= data_next;
            if (pop) record <= mem[rd_ptr];
        end
    end

endmodule

// File: doc/cpu_bus_tracer.md
# cpu_bus_tracer

Captures one 6502C external bus cycle per CPU phase strobe (address, data, R/W, SYNC) into a small FIFO and streams each captured cycle as a 10-character ASCII record to the LCD controller using its write_start/write_done/clear_all handshake. It sits between the CPU core's external bus and lcd_control, as an alternative text source to the register-display FSM. It consumes what the CPU produces and feeds the LCD character port.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- clk  in  1  system clock (the LCD/FSM clock domain)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  capture enable; when low, strobes are ignored (drain continues)
- cycle_strobe  in  1  single-clk pulse, synchronous to clk, once per CPU phi1 cycle
- addr  in  16  {extABH, extABL}, valid when cycle_strobe=1
- data  in  8  extDB, valid when cycle_strobe=1
- rw  in  1  1=read, 0=write
- sync  in  1  opcode-fetch marker
- init_done  in  1  LCD controller initialised
- write_done  in  1  single-clk pulse: LCD finished the current char or clear
- write_start  out  1  single-clk pulse: data_out valid, start write
- data_out  out  8  ASCII character to LCD
- clear_all  out  1  single-clk pulse: clear LCD before a record
- overflow  out  1  sticky: a sample was dropped
- drop_count  out  8  dropped samples, saturates at 255
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Entry = {addr, data, rw, sync}, 26 bits.
- Push: cycle_strobe && enable. Accepted if not full, or if full and a pop occurs in the same clk. Otherwise it is dropped: overflow<=1, drop_count increments, saturating at 8'hFF.
- Record format, 10 chars: A[15:12] A[11:8] A[7:4] A[3:0] ' ' D[7:4] D[3:0] ' ' RW S.
  - Hex nibble n: n<10 -> 8'h30+n; otherwise 8'h41+n-10 (uppercase).
  - RW char: 'R' (8'h52) if rw=1, 'W' (8'h57) if rw=0.
  - S char: '*' (8'h2A) if sync=1, ' ' (8'h20) if sync=0.
- FSM states:
  - IDLE: if init_done && !empty: pop head into record register, pulse clear_all, go to WAIT_CLR.
  - WAIT_CLR: on write_done, set idx=0 and go to SEND.
  - SEND: data_out=char[idx], pulse write_start, go to WAIT_CHR.
  - WAIT_CHR: on write_done, go to IDLE if idx==9; otherwise idx++ and go to SEND.
- write_done is ignored in IDLE and SEND.
- data_out holds its value from SEND until the next SEND.
- init_done falling mid-record does not abort the record; it only blocks starting the next one.
- Entries drain strictly in capture order.

## Timing
- Reset values:
  - write_start=0, clear_all=0, data_out=8'h00
  - overflow=0, drop_count=0, fifo_level=0
  - FIFO empty, FSM in IDLE, idx=0
- Reset mid-record: the partial record is abandoned and queued entries are discarded. No write_start or clear_all is issued until a new push has occurred after reset deassertion.
- Push written at the clk edge where the strobe is high; fifo_level updates the same edge; the entry is eligible for pop on the next cycle.
- Minimum strobe-to-clear_all latency with an empty FIFO, init_done=1 and FSM in IDLE: 2 clk.
- write_done -> next write_start: 2 clk (the SEND state registers the pulse).
- A record needs 11 write_done pulses in total: 1 clear plus 10 characters.
- All outputs are registered.
- Simultaneous push and pop: fifo_level unchanged, including when full.

## Test plan
- Single record: init_done=1, strobe with addr=16'hFFFC, data=8'h00, rw=1, sync=0; write_done returned 3 clk after each request -> one clear_all, then data_out 46 46 46 43 20 30 30 20 52 20 with one write_start each; FSM returns to IDLE with fifo_level=0.
- Overflow: init_done=0, DEPTH=8, 10 strobes with addr=0..9 -> fifo_level=8, overflow=1, drop_count=2. Then set init_done=1 -> records for addr 0000..0007 in order; overflow stays 1.
- Full plus simultaneous pop: FIFO full, strobe in the same clk as the IDLE pop -> sample accepted, fifo_level stays 8, drop_count unchanged.
- Sync/write format: addr=16'h0600, data=8'hA9, rw=0, sync=1 -> "0600 A9 W*" (30 36 30 30 20 41 39 20 57 2A).
- Reset mid-record: assert rst after the 4th character -> all outputs return to reset values immediately. After release, 50 clk of write_done pulses produce no write_start.
- Drop saturation: enable=1, init_done=0, 300 strobes on a full FIFO -> drop_count=255. enable=0 strobes are neither counted nor stored.
